// File: rtl/fifo_rdptr_empty_if.sv
// Read-side bus of the async FIFO pointer block: read request, synchronised write pointer, status.
// RLEVEL is present only when FIFO_RD_LEVEL_EN is defined.
interface fifo_rdptr_empty_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              R_INC;
  logic [ADDR_W:0]   gray_Wptr;
  logic              REMPTY;
  logic [ADDR_W-1:0] Raddr;
  logic [ADDR_W:0]   gray_Rptr;
`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_W:0]   RLEVEL;
`endif

  modport master (
    output R_INC,
    output gray_Wptr,
    input  REMPTY,
    input  Raddr,
    input  gray_Rptr
`ifdef FIFO_RD_LEVEL_EN
    , input RLEVEL
`endif
  );

  modport slave (
    input  R_INC,
    input  gray_Wptr,
    output REMPTY,
    output Raddr,
    output gray_Rptr
`ifdef FIFO_RD_LEVEL_EN
    , output RLEVEL
`endif
  );
endinterface

// File: rtl/fifo_rdptr_empty.sv
// Read pointer, RAM read address, gray pointer export and registered empty flag of the async FIFO.
// Define FIFO_RD_LEVEL_EN to add the registered occupancy output RLEVEL.
module fifo_rdptr_empty #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              R_CLK,
  input  logic              R_RST,
  fifo_rdptr_empty_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_rdptr_empty: DEPTH must be a power of two >= 4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("fifo_rdptr_empty: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
  logic [PTR_W-1:0] wq_gray;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] rptr_nxt;
  logic [PTR_W-1:0] rgray_q;
  logic [PTR_W-1:0] rgray_nxt;
  logic             rempty_q;
  logic             rd_ok;

  // Plain flop chain for the write pointer; index 0 is the newest sample
  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.gray_Wptr};
    end
  end

  assign wq_gray   = sync_q[SYNC_STAGES-1];
  assign rd_ok     = bus.R_INC & ~rempty_q;
  assign rptr_nxt  = rptr_q + PTR_W'(rd_ok);
  assign rgray_nxt = rptr_nxt ^ (rptr_nxt >> 1);

  // Empty is judged against the pointer value after this edge's read, so the last read sets it
  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      rptr_q   <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
    end else begin
      rptr_q   <= rptr_nxt;
      rgray_q  <= rgray_nxt;
      rempty_q <= (rgray_nxt == wq_gray);
    end
  end

  assign bus.Raddr     = rptr_q[ADDR_W-1:0];
  assign bus.gray_Rptr = rgray_q;
  assign bus.REMPTY    = rempty_q;

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_W-1:0] wq_bin;
  logic [PTR_W-1:0] rlevel_q;

  // Bit i of the binary value is the XOR of all gray bits at or above i
  always_comb begin
    wq_bin = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      wq_bin[i] = ^(wq_gray >> i);
    end
  end

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      rlevel_q <= '0;
    end else begin
      rlevel_q <= wq_bin - rptr_nxt;
    end
  end

  assign bus.RLEVEL = rlevel_q;
`endif

endmodule

// File: tb/tb_fifo_rdptr_empty.sv
// Self-checking bench for fifo_rdptr_empty: directed scenarios plus randomized traffic
// compared against a count-based model of the read side.
module tb_fifo_rdptr_empty;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic R_CLK = 1'b0;
  logic R_RST = 1'b0;
  int   wcnt  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: total reads since reset, write count the reader has seen, flags
  int   m_rd_total = 0;
  int   m_seen     = 0;
  int   m_lvl      = 0;
  bit   m_empty    = 1'b1;
  int   m_samp[$];

  fifo_rdptr_empty_if #(.ADDR_W(ADDR_W)) bus ();

  fifo_rdptr_empty #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .R_CLK (R_CLK),
    .R_RST (R_RST),
    .bus   (bus)
  );

  function automatic logic [PTR_W-1:0] to_gray(input int b);
    logic [PTR_W-1:0] v;
    v = PTR_W'(b);
    return v ^ (v >> 1);
  endfunction

  always #5 R_CLK = ~R_CLK;

  assign bus.gray_Wptr = to_gray(wcnt);

  // Reader sees the write count sampled SYNC edges earlier; empty when it equals reads done
  always @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      m_rd_total = 0;
      m_empty    = 1'b1;
      m_lvl      = 0;
      m_samp.delete();
      for (int i = 0; i < int'(SYNC); i++) m_samp.push_back(0);
    end else begin
      m_seen = m_samp.pop_front();
      m_samp.push_back(wcnt);
      if (bus.R_INC && m_empty == 1'b0) m_rd_total++;
      m_empty = (m_seen == m_rd_total);
      m_lvl   = m_seen - m_rd_total;
    end
  end

  task automatic do_reset();
    @(negedge R_CLK);
    bus.R_INC = 1'b0;
    wcnt      = 0;
    #1 R_RST  = 1'b1;
    #2 R_RST  = 1'b0;
  endtask

  task automatic test_reset();
    bus.R_INC = 1'b0;
    wcnt      = 0;
    #2 R_RST  = 1'b1;
    #1;
    n_tests++;
    if (bus.REMPTY !== 1'b1) begin
      n_fail++; $display("FAIL reset_rempty got %b want 1", bus.REMPTY);
    end
    n_tests++;
    if (bus.Raddr !== 4'd0) begin
      n_fail++; $display("FAIL reset_raddr got %0d want 0", bus.Raddr);
    end
    n_tests++;
    if (bus.gray_Rptr !== 5'b00000) begin
      n_fail++; $display("FAIL reset_gray_rptr got %b want 00000", bus.gray_Rptr);
    end
`ifdef FIFO_RD_LEVEL_EN
    n_tests++;
    if (bus.RLEVEL !== 5'd0) begin
      n_fail++; $display("FAIL reset_rlevel got %0d want 0", bus.RLEVEL);
    end
`endif
    @(negedge R_CLK);
    R_RST = 1'b0;
  endtask

  task automatic test_first_write();
    wcnt = 1;
    repeat (2) @(negedge R_CLK);
    n_tests++;
    if (bus.REMPTY !== m_empty) begin
      n_fail++; $display("FAIL first_write_edge2 rempty got %b want %b", bus.REMPTY, m_empty);
    end
    @(negedge R_CLK);
    n_tests++;
    if (bus.REMPTY !== 1'b0) begin
      n_fail++; $display("FAIL first_write_edge3 rempty got %b want 0", bus.REMPTY);
    end
    bus.R_INC = 1'b1;
    @(negedge R_CLK);
    bus.R_INC = 1'b0;
    n_tests++;
    if (bus.Raddr !== 4'd1 || bus.gray_Rptr !== 5'b00001 || bus.REMPTY !== 1'b1) begin
      n_fail++;
      $display("FAIL last_read got raddr=%0d gray=%b empty=%b want raddr=1 gray=00001 empty=1",
               bus.Raddr, bus.gray_Rptr, bus.REMPTY);
    end
  endtask

  task automatic test_read_when_empty();
    do_reset();
    @(negedge R_CLK);
    bus.R_INC = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge R_CLK);
      n_tests++;
      if (bus.Raddr !== 4'd0 || bus.gray_Rptr !== 5'b00000 || bus.REMPTY !== 1'b1) begin
        n_fail++;
        $display("FAIL empty_read cyc%0d got raddr=%0d gray=%b empty=%b want 0/00000/1",
                 c, bus.Raddr, bus.gray_Rptr, bus.REMPTY);
      end
    end
    bus.R_INC = 1'b0;
  endtask

  task automatic test_wrap();
    logic [PTR_W-1:0] prev_g;
    int prev_rd;
    bit done;
    do_reset();
    @(negedge R_CLK);
    prev_g  = bus.gray_Rptr;
    prev_rd = m_rd_total;
    done    = 1'b0;
    bus.R_INC = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      if (wcnt < 32 && (wcnt - m_rd_total) < int'(DEPTH)) wcnt++;
      @(negedge R_CLK);
      n_tests++;
      if (bus.Raddr !== 4'(m_rd_total % 16) || bus.gray_Rptr !== to_gray(m_rd_total) ||
          bus.REMPTY !== m_empty) begin
        n_fail++;
        $display("FAIL wrap cyc%0d got raddr=%0d gray=%b empty=%b want raddr=%0d gray=%b empty=%b",
                 c, bus.Raddr, bus.gray_Rptr, bus.REMPTY, m_rd_total % 16,
                 to_gray(m_rd_total), m_empty);
      end
      n_tests++;
      if ($countones(prev_g ^ bus.gray_Rptr) != ((m_rd_total != prev_rd) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL wrap_onebit cyc%0d got %b->%b", c, prev_g, bus.gray_Rptr);
      end
      if (m_rd_total == 16 && prev_rd == 15) begin
        n_tests++;
        if (bus.gray_Rptr !== 5'b11000) begin
          n_fail++; $display("FAIL wrap_16 gray got %b want 11000", bus.gray_Rptr);
        end
      end
      if (m_rd_total == 32) begin
        n_tests++;
        if (bus.gray_Rptr !== 5'b00000 || bus.Raddr !== 4'd0) begin
          n_fail++;
          $display("FAIL wrap_32 got gray=%b raddr=%0d want 00000/0", bus.gray_Rptr, bus.Raddr);
        end
        done = 1'b1;
      end
      prev_g  = bus.gray_Rptr;
      prev_rd = m_rd_total;
    end
    bus.R_INC = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL wrap_timeout got %0d reads want 32", m_rd_total);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    @(negedge R_CLK);
    wcnt = 8;
    bus.R_INC = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge R_CLK);
      if (m_rd_total == 5) begin
        bus.R_INC = 1'b0;
        ok = 1'b1;
      end
    end
    n_tests++;
    if (!ok || bus.Raddr !== 4'd5) begin
      n_fail++; $display("FAIL mid_pre_reset raddr got %0d want 5", bus.Raddr);
    end
    #2 R_RST = 1'b1;
    wcnt = 0;
    #1;
    n_tests++;
    if (bus.REMPTY !== 1'b1 || bus.Raddr !== 4'd0 || bus.gray_Rptr !== 5'b00000) begin
      n_fail++;
      $display("FAIL mid_reset got empty=%b raddr=%0d gray=%b want 1/0/00000",
               bus.REMPTY, bus.Raddr, bus.gray_Rptr);
    end
    #1 R_RST = 1'b0;
    @(negedge R_CLK);
    wcnt = 3;
    bus.R_INC = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge R_CLK);
      if (m_rd_total == 1) ok = 1'b1;
    end
    bus.R_INC = 1'b0;
    n_tests++;
    if (!ok || bus.Raddr !== 4'd1) begin
      n_fail++; $display("FAIL mid_restart raddr got %0d want 1", bus.Raddr);
    end
  endtask

`ifdef FIFO_RD_LEVEL_EN
  task automatic test_level();
    bit ok;
    do_reset();
    @(negedge R_CLK);
    wcnt = 16;
    repeat (4) @(negedge R_CLK);
    n_tests++;
    if (bus.RLEVEL !== 5'd16) begin
      n_fail++; $display("FAIL level_full got %0d want 16", bus.RLEVEL);
    end
    bus.R_INC = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge R_CLK);
      if (m_rd_total == 4) begin
        bus.R_INC = 1'b0;
        ok = 1'b1;
      end
    end
    n_tests++;
    if (!ok || bus.RLEVEL !== 5'd12) begin
      n_fail++; $display("FAIL level_after4 got %0d want 12", bus.RLEVEL);
    end
  endtask
`endif

  task automatic test_random();
    logic [PTR_W-1:0] prev_g;
    int prev_rd;
    do_reset();
    @(negedge R_CLK);
    prev_g  = bus.gray_Rptr;
    prev_rd = m_rd_total;
    for (int c = 0; c < 400; c++) begin
      bus.R_INC = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && (wcnt - m_rd_total) < int'(DEPTH)) wcnt++;
      @(negedge R_CLK);
      n_tests++;
      if (bus.Raddr !== 4'(m_rd_total % 16) || bus.gray_Rptr !== to_gray(m_rd_total) ||
          bus.REMPTY !== m_empty) begin
        n_fail++;
        $display("FAIL random cyc%0d got raddr=%0d gray=%b empty=%b want raddr=%0d gray=%b empty=%b",
                 c, bus.Raddr, bus.gray_Rptr, bus.REMPTY, m_rd_total % 16,
                 to_gray(m_rd_total), m_empty);
      end
      n_tests++;
      if ($countones(prev_g ^ bus.gray_Rptr) != ((m_rd_total != prev_rd) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL random_onebit cyc%0d got %b->%b", c, prev_g, bus.gray_Rptr);
      end
`ifdef FIFO_RD_LEVEL_EN
      n_tests++;
      if (bus.RLEVEL !== 5'(m_lvl)) begin
        n_fail++; $display("FAIL random_level cyc%0d got %0d want %0d", c, bus.RLEVEL, m_lvl);
      end
`endif
      prev_g  = bus.gray_Rptr;
      prev_rd = m_rd_total;
    end
    bus.R_INC = 1'b0;
  endtask

  initial begin
    bus.R_INC = 1'b0;
    test_reset();
    test_first_write();
    test_read_when_empty();
    test_wrap();
    test_reset_mid();
`ifdef FIFO_RD_LEVEL_EN
    test_level();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d tests", n_tests);
    $fatal(1);
  end

endmodule
